// File: rtl/blaster_pkg.sv
// Shared blaster definitions: ADC sequencer state/channel enums and default converter timing.
package blaster_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        QUIET
    } adc_seq_state_t;

    // Channel order doubles as the lane index {LV, LI, CV, CI} used by adc_seq.
    typedef enum logic [1:0] {
        CH_CI,
        CH_CV,
        CH_LI,
        CH_LV
    } adc_chan_t;

    localparam int ADC_SAMPLE_BITS  = 12;
    localparam int ADC_LEAD_BITS    = 2;
    localparam int ADC_FRAME_CYCLES = 16;
    localparam int ADC_QUIET_CYCLES = 2;

endpackage

// File: rtl/adc_lane_shift.sv
// One converter lane: MSB-first shift register, sample latch and optional peak hold.
// Peak hold is built only when ADC_SEQ_PEAK_EN is defined; otherwise pk reads 0.
module adc_lane_shift
    import blaster_pkg::*;
#(
    parameter int SAMPLE_BITS = ADC_SAMPLE_BITS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   shift_en,
    input  logic                   load,
    input  logic                   lane,
    input  logic                   pk_clr,
    output logic [SAMPLE_BITS-1:0] smp,
    output logic [SAMPLE_BITS-1:0] pk
);

    logic [SAMPLE_BITS-1:0] shreg;

    // The shift register is deliberately not cleared between frames.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg <= '0;
            smp   <= '0;
        end else begin
            if (shift_en) begin
                shreg <= {shreg[SAMPLE_BITS-2:0], lane};
            end
            if (load) begin
                smp <= shreg;
            end
        end
    end

`ifdef ADC_SEQ_PEAK_EN
    // A clear coinciding with a new sample restarts the peak from that sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pk <= '0;
        end else if (pk_clr && load) begin
            pk <= shreg;
        end else if (pk_clr) begin
            pk <= '0;
        end else if (load && (shreg > pk)) begin
            pk <= shreg;
        end
    end
`else
    logic unused_pk_clr;
    assign unused_pk_clr = pk_clr;
    assign pk = '0;
`endif

endmodule

// File: rtl/adc_seq.sv
// Dual-converter ADC sequencer: frames ad_cs, deserialises CI/CV/LI/LV, strobes sample sets.
// Optional peak hold per channel is enabled with ADC_SEQ_PEAK_EN.
module adc_seq
    import blaster_pkg::*;
#(
    parameter int SAMPLE_BITS  = ADC_SAMPLE_BITS,
    parameter int LEAD_BITS    = ADC_LEAD_BITS,
    parameter int FRAME_CYCLES = ADC_FRAME_CYCLES,
    parameter int QUIET_CYCLES = ADC_QUIET_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   trig,
    input  logic                   clr_miss,
    output logic                   ad_cs,
    input  logic [1:0]             ad_sdata_a,
    input  logic [1:0]             ad_sdata_b,
    output logic                   busy,
    output logic                   smp_valid,
    output logic [SAMPLE_BITS-1:0] smp_ci,
    output logic [SAMPLE_BITS-1:0] smp_cv,
    output logic [SAMPLE_BITS-1:0] smp_li,
    output logic [SAMPLE_BITS-1:0] smp_lv,
    output logic [15:0]            frame_cnt,
    output logic                   trig_miss,
    output logic [SAMPLE_BITS-1:0] pk_ci,
    output logic [SAMPLE_BITS-1:0] pk_cv,
    output logic [SAMPLE_BITS-1:0] pk_li,
    output logic [SAMPLE_BITS-1:0] pk_lv,
    input  logic                   pk_clr
);

    localparam int CW = $clog2(FRAME_CYCLES + 1);
    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LEAD_LO  = CW'(LEAD_BITS);
    localparam logic [CW-1:0] LEAD_HI  = CW'(LEAD_BITS + SAMPLE_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_CYCLES - 1);
    localparam logic [QW-1:0] Q_LAST   = QW'(QUIET_CYCLES - 1);

    adc_seq_state_t state;
    logic [CW-1:0]  bit_cnt;
    logic [QW-1:0]  q_cnt;
    logic           shift_en;
    logic           load;
    logic [3:0]     lane_bits;
    logic [SAMPLE_BITS-1:0] smp [4];
    logic [SAMPLE_BITS-1:0] pk  [4];

    // Sequencer: busy mirrors "not IDLE" so a trig can be judged missed without decoding state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            ad_cs     <= 1'b1;
            busy      <= 1'b0;
            smp_valid <= 1'b0;
            bit_cnt   <= '0;
            q_cnt     <= '0;
            frame_cnt <= '0;
            trig_miss <= 1'b0;
        end else begin
            smp_valid <= 1'b0;
            if (trig && busy) begin
                trig_miss <= 1'b1;
            end else if (clr_miss) begin
                trig_miss <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (enable || trig) begin
                        state   <= CONV;
                        ad_cs   <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                CONV: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state     <= QUIET;
                        ad_cs     <= 1'b1;
                        smp_valid <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                        q_cnt     <= '0;
                    end
                end
                QUIET: begin
                    q_cnt <= q_cnt + 1'b1;
                    if (q_cnt == Q_LAST) begin
                        if (enable) begin
                            state   <= CONV;
                            ad_cs   <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    ad_cs <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign shift_en  = (state == CONV) && (bit_cnt >= LEAD_LO) && (bit_cnt < LEAD_HI);
    assign load      = (state == CONV) && (bit_cnt == LAST_BIT);
    assign lane_bits = {ad_sdata_b, ad_sdata_a};

    for (genvar ch = 0; ch < 4; ch++) begin : g_lane
        adc_lane_shift #(
            .SAMPLE_BITS(SAMPLE_BITS)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .shift_en(shift_en),
            .load    (load),
            .lane    (lane_bits[ch]),
            .pk_clr  (pk_clr),
            .smp     (smp[ch]),
            .pk      (pk[ch])
        );
    end

    assign smp_ci = smp[CH_CI];
    assign smp_cv = smp[CH_CV];
    assign smp_li = smp[CH_LI];
    assign smp_lv = smp[CH_LV];
    assign pk_ci  = pk[CH_CI];
    assign pk_cv  = pk[CH_CV];
    assign pk_li  = pk[CH_LI];
    assign pk_lv  = pk[CH_LV];

endmodule
